// File: rtl/dp_share_arbiter_pkg.sv
// Shared types and constants for the two-requester datapath arbiter.
package dp_arb_pkg;

    localparam int OP_W = 3;

    typedef logic req_id_t;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

endpackage

// File: rtl/dp_share_arbiter_if.sv
// Bundle of requester handshakes, datapath operand/result wires and tagged result return.
interface dp_share_arbiter_if #(
    parameter int N = 16
);
    import dp_arb_pkg::*;

    logic            req0_valid;
    logic            req0_ready;
    logic [N-1:0]    req0_a;
    logic [N-1:0]    req0_b;
    logic [OP_W-1:0] req0_op;

    logic            req1_valid;
    logic            req1_ready;
    logic [N-1:0]    req1_a;
    logic [N-1:0]    req1_b;
    logic [OP_W-1:0] req1_op;

    logic [N-1:0]    dp_a;
    logic [N-1:0]    dp_b;
    logic [OP_W-1:0] dp_op;
    logic [N-1:0]    dp_y;
    logic            dp_co;

    logic            res_valid;
    logic            res_id;
    logic [N-1:0]    res_y;
    logic            res_co;
    logic            busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  dp_a, dp_b, dp_op,
        output dp_y, dp_co,
        input  res_valid, res_id, res_y, res_co, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output dp_a, dp_b, dp_op,
        input  dp_y, dp_co,
        output res_valid, res_id, res_y, res_co, busy
    );

endinterface

// File: rtl/dp_share_arbiter_tag_pipe.sv
// Delay line carrying each issued op's owner alongside the datapath latency.
module dp_tag_pipe
    import dp_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t stage [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every stage samples its
    // predecessor's pre-edge value; blocking here would collapse the shift into one hop.
    // NOTE: this storage is reset, unlike a data RAM, because stale valid bits would
    // emit phantom results after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dp_share_arbiter.sv
// Round-robin issue of two requesters onto one pipelined datapath with tagged, in-order result return.
// Optional feature macro DP_ARB_STATS_EN adds saturating per-requester grant counters.
module dp_share_arbiter
    import dp_arb_pkg::*;
#(
    parameter int N    = 16,
    parameter int PIPE = 1
) (
    input logic               clk,
    input logic               rst,
    dp_share_arbiter_if.slave bus
`ifdef DP_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1
`endif
);

    req_id_t         ptr;
    logic            grant0;
    logic            grant1;
    logic            grant;
    req_id_t         grant_id;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [OP_W-1:0] sel_op;
    tag_t            tag_in;
    tag_t            tag_out;
    logic            tag_any;

    // NOTE: every signal is assigned on every pass through this block, so no latch is inferred.
    always_comb begin
        grant0   = bus.req0_valid && (!bus.req1_valid || ptr == 1'b0);
        grant1   = bus.req1_valid && (!bus.req0_valid || ptr == 1'b1);
        grant    = grant0 || grant1;
        grant_id = req_id_t'(grant1);
        sel_a    = grant1 ? bus.req1_a  : bus.req0_a;
        sel_b    = grant1 ? bus.req1_b  : bus.req0_b;
        sel_op   = grant1 ? bus.req1_op : bus.req0_op;
        tag_in   = '{valid: grant, id: grant_id};
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= 1'b0;
            bus.dp_a  <= '0;
            bus.dp_b  <= '0;
            bus.dp_op <= '0;
        end else if (grant) begin
            ptr       <= ~grant_id;
            bus.dp_a  <= sel_a;
            bus.dp_b  <= sel_b;
            bus.dp_op <= sel_op;
        end
    end

    // One extra stage covers the operand register in front of the datapath.
    dp_tag_pipe #(
        .DEPTH(PIPE + 1)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .tag_in   (tag_in),
        .tag_out  (tag_out),
        .any_valid(tag_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.res_y     <= '0;
            bus.res_co    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.res_valid <= tag_out.valid;
            if (tag_out.valid) begin
                bus.res_id <= tag_out.id;
                bus.res_y  <= bus.dp_y;
                bus.res_co <= bus.dp_co;
            end
            // Pre-edge occupancy keeps busy high through the final result pulse.
            bus.busy <= grant || tag_any;
        end
    end

`ifdef DP_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0 && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
            if (grant1 && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Bench for dp_share_arbiter: PIPE=1 and PIPE=0 instances, behavioural datapaths, result scoreboards.
module tb_dp_share_arbiter;
    import dp_arb_pkg::*;

    localparam int N = 16;

    typedef struct {
        logic         id;
        logic [N-1:0] y;
        logic         co;
        int           due;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;
    exp_t q1[$];
    exp_t q0[$];
    exp_t e1;
    exp_t e0;
    int   pulses;

    dp_share_arbiter_if #(.N(N)) if1 ();
    dp_share_arbiter_if #(.N(N)) if0 ();

`ifdef DP_ARB_STATS_EN
    logic [15:0] gc0_1, gc1_1, gc0_0, gc1_0;
`endif

    dp_share_arbiter #(.N(N), .PIPE(1)) u1 (
        .clk(clk),
        .rst(rst),
        .bus(if1)
`ifdef DP_ARB_STATS_EN
        ,
        .grant_cnt0(gc0_1),
        .grant_cnt1(gc1_1)
`endif
    );

    dp_share_arbiter #(.N(N), .PIPE(0)) u0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
`ifdef DP_ARB_STATS_EN
        ,
        .grant_cnt0(gc0_0),
        .grant_cnt1(gc1_0)
`endif
    );

    function automatic logic [N:0] dp_fn(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
        case (op)
            3'b000:  return {1'b0, a} + {1'b0, b};
            3'b001:  return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    function automatic exp_t mk(input logic id, input logic [2:0] op, input logic [N-1:0] a,
                                input logic [N-1:0] b, input int due);
        logic [N:0] r;
        exp_t       e;
        r     = dp_fn(op, a, b);
        e.id  = id;
        e.y   = r[N-1:0];
        e.co  = r[N];
        e.due = due;
        return e;
    endfunction

    // Behavioural datapaths: one register stage for u1, purely combinational for u0.
    logic [N:0] dp1_r;
    always @(posedge clk) dp1_r <= dp_fn(if1.dp_op, if1.dp_a, if1.dp_b);
    assign if1.dp_y  = dp1_r[N-1:0];
    assign if1.dp_co = dp1_r[N];
    assign {if0.dp_co, if0.dp_y} = dp_fn(if0.dp_op, if0.dp_a, if0.dp_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every transfer with the negedge index at which its result must appear.
    always @(posedge clk) begin
        if (!rst) begin
            if (if1.req0_valid && if1.req0_ready)
                q1.push_back(mk(1'b0, if1.req0_op, if1.req0_a, if1.req0_b, edge_cnt + 3));
            if (if1.req1_valid && if1.req1_ready)
                q1.push_back(mk(1'b1, if1.req1_op, if1.req1_a, if1.req1_b, edge_cnt + 3));
            if (if0.req0_valid && if0.req0_ready)
                q0.push_back(mk(1'b0, if0.req0_op, if0.req0_a, if0.req0_b, edge_cnt + 2));
            if (if0.req1_valid && if0.req1_ready)
                q0.push_back(mk(1'b1, if0.req1_op, if0.req1_a, if0.req1_b, edge_cnt + 2));
        end
        edge_cnt <= edge_cnt + 1;
    end

    always @(negedge clk) begin
        if (!rst && if1.res_valid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected_result id=%0d y=%0h at edge %0d, none required",
                         if1.res_id, if1.res_y, edge_cnt);
            end else begin
                e1 = q1.pop_front();
                if (if1.res_id !== e1.id || if1.res_y !== e1.y || if1.res_co !== e1.co ||
                    edge_cnt != e1.due) begin
                    errors++;
                    $display("FAIL u1_result got id=%0d y=%0h co=%0d edge=%0d want id=%0d y=%0h co=%0d edge=%0d",
                             if1.res_id, if1.res_y, if1.res_co, edge_cnt, e1.id, e1.y, e1.co, e1.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if0.res_valid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL u0_unexpected_result id=%0d y=%0h at edge %0d, none required",
                         if0.res_id, if0.res_y, edge_cnt);
            end else begin
                e0 = q0.pop_front();
                if (if0.res_id !== e0.id || if0.res_y !== e0.y || if0.res_co !== e0.co ||
                    edge_cnt != e0.due) begin
                    errors++;
                    $display("FAIL u0_result got id=%0d y=%0h co=%0d edge=%0d want id=%0d y=%0h co=%0d edge=%0d",
                             if0.res_id, if0.res_y, if0.res_co, edge_cnt, e0.id, e0.y, e0.co, e0.due);
                end
            end
        end
    end

    task automatic idle_inputs();
        if1.req0_valid = 1'b0; if1.req0_a = '0; if1.req0_b = '0; if1.req0_op = OP_ADD;
        if1.req1_valid = 1'b0; if1.req1_a = '0; if1.req1_b = '0; if1.req1_op = OP_ADD;
        if0.req0_valid = 1'b0; if0.req0_a = '0; if0.req0_b = '0; if0.req0_op = OP_ADD;
        if0.req1_valid = 1'b0; if0.req1_a = '0; if0.req1_b = '0; if0.req1_op = OP_ADD;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        q1.delete();
        q0.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({if1.res_valid, if1.busy, if1.dp_a, if1.dp_b, if1.dp_op, if1.res_y, if1.res_co,
             if1.res_id} !== '0) begin
            errors++;
            $display("FAIL reset_u1 got valid=%0b busy=%0b dp_a=%0h res_y=%0h want all zero",
                     if1.res_valid, if1.busy, if1.dp_a, if1.res_y);
        end
        checks++;
        if ({if0.res_valid, if0.busy, if0.dp_a, if0.dp_b, if0.dp_op, if0.res_y, if0.res_co,
             if0.res_id} !== '0) begin
            errors++;
            $display("FAIL reset_u0 got valid=%0b busy=%0b dp_a=%0h res_y=%0h want all zero",
                     if0.res_valid, if0.busy, if0.dp_a, if0.res_y);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        if1.req0_valid = 1'b1; if1.req0_a = 16'd100; if1.req0_b = 16'd23; if1.req0_op = OP_ADD;
        #1;
        checks++;
        if (if1.req0_ready !== 1'b1) begin
            errors++; $display("FAIL single_ready got %0b want 1", if1.req0_ready);
        end
        @(posedge clk);
        @(negedge clk);
        if1.req0_valid = 1'b0;
        checks++;
        if (if1.res_valid !== 1'b0 || if1.busy !== 1'b1) begin
            errors++;
            $display("FAIL single_e0 got valid=%0b busy=%0b want valid=0 busy=1", if1.res_valid, if1.busy);
        end
        @(negedge clk);
        checks++;
        if (if1.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_e1_valid got %0b want 0", if1.res_valid);
        end
        @(negedge clk);
        checks++;
        if (if1.res_valid !== 1'b1 || if1.res_y !== 16'd123 || if1.res_id !== 1'b0 || if1.res_co !== 1'b0) begin
            errors++;
            $display("FAIL single_e2 got valid=%0b y=%0d id=%0d co=%0d want valid=1 y=123 id=0 co=0",
                     if1.res_valid, if1.res_y, if1.res_id, if1.res_co);
        end
        @(negedge clk);
        checks++;
        if (if1.res_valid !== 1'b0 || if1.busy !== 1'b0 || if1.res_y !== 16'd123) begin
            errors++;
            $display("FAIL single_e3 got valid=%0b busy=%0b y=%0d want valid=0 busy=0 y=123",
                     if1.res_valid, if1.busy, if1.res_y);
        end
        // Carry case: 0xFFFF + 1 wraps to zero with carry-out.
        if1.req0_valid = 1'b1; if1.req0_a = 16'hFFFF; if1.req0_b = 16'd1;
        @(posedge clk);
        @(negedge clk);
        if1.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (if1.res_valid !== 1'b1 || if1.res_y !== 16'h0000 || if1.res_co !== 1'b1) begin
            errors++;
            $display("FAIL single_carry got valid=%0b y=%0h co=%0d want valid=1 y=0 co=1",
                     if1.res_valid, if1.res_y, if1.res_co);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if1.req0_valid = 1'b1; if1.req0_a = 16'(10 * i + 50); if1.req0_b = 16'd7; if1.req0_op = 3'b001;
            if1.req1_valid = 1'b1; if1.req1_a = 16'd3;  if1.req1_b = 16'(i); if1.req1_op = 3'b001;
            #1;
            checks++;
            if (if1.req0_ready !== (i % 2 == 0) || if1.req1_ready !== (i % 2 == 1) ||
                if1.res_valid !== (i == 3)) begin
                errors++;
                $display("FAIL contention_grant_%0d got r0=%0b r1=%0b valid=%0b want r0=%0b r1=%0b valid=%0b",
                         i, if1.req0_ready, if1.req1_ready, if1.res_valid, i % 2 == 0, i % 2 == 1, i == 3);
            end
            @(posedge clk);
            @(negedge clk);
        end
        if1.req0_valid = 1'b0;
        if1.req1_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            #1;
            checks++;
            if (if1.res_valid !== (j < 3) || if1.busy !== (j < 3)) begin
                errors++;
                $display("FAIL contention_tail_%0d got valid=%0b busy=%0b want valid=%0b busy=%0b",
                         j, if1.res_valid, if1.busy, j < 3, j < 3);
            end
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if1.req1_valid = 1'b1; if1.req1_a = 16'(i); if1.req1_b = 16'd1; if1.req1_op = OP_ADD;
            #1;
            checks++;
            if (if1.req1_ready !== 1'b1 || if1.req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL stream_ready_%0d got r1=%0b r0=%0b want r1=1 r0=0",
                         i, if1.req1_ready, if1.req0_ready);
            end
            @(posedge clk);
        end
        @(negedge clk);
        if1.req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (if1.res_valid !== 1'b0 || if1.res_y !== 16'd8 || if1.res_id !== 1'b1) begin
            errors++;
            $display("FAIL stream_last got valid=%0b y=%0d id=%0d want valid=0 y=8 id=1",
                     if1.res_valid, if1.res_y, if1.res_id);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        if1.req1_valid = 1'b1; if1.req1_a = 16'd5; if1.req1_b = 16'd5;
        @(posedge clk);
        @(negedge clk);
        if1.req1_valid = 1'b0;
        if1.req0_valid = 1'b1; if1.req0_a = 16'd6; if1.req0_b = 16'd6;
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        q1.delete();
        q0.delete();
        #1;
        checks++;
        if ({if1.res_valid, if1.busy, if1.dp_a, if1.dp_b, if1.dp_op, if1.res_y, if1.res_id} !== '0) begin
            errors++;
            $display("FAIL midflight_reset got valid=%0b busy=%0b dp_a=%0h res_y=%0h want all zero",
                     if1.res_valid, if1.busy, if1.dp_a, if1.res_y);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (if1.res_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL midflight_no_result got %0d pulses want 0", pulses);
        end
        if1.req0_valid = 1'b1; if1.req0_a = 16'd9; if1.req0_b = 16'd1;
        if1.req1_valid = 1'b1; if1.req1_a = 16'd4; if1.req1_b = 16'd4;
        #1;
        checks++;
        if (if1.req0_ready !== 1'b1 || if1.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL midflight_ptr got r0=%0b r1=%0b want r0=1 r1=0", if1.req0_ready, if1.req1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_pipe0();
        if0.req0_valid = 1'b1; if0.req0_a = -16'sd5; if0.req0_b = 16'sd3; if0.req0_op = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        if0.req0_valid = 1'b0;
        checks++;
        if (if0.res_valid !== 1'b0 || if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL pipe0_k got valid=%0b busy=%0b want valid=0 busy=1", if0.res_valid, if0.busy);
        end
        @(negedge clk);
        checks++;
        if (if0.res_valid !== 1'b1 || if0.res_y !== 16'hFFFE || if0.res_id !== 1'b0 || if0.res_co !== 1'b0) begin
            errors++;
            $display("FAIL pipe0_k1 got valid=%0b y=%0h id=%0d co=%0d want valid=1 y=fffe id=0 co=0",
                     if0.res_valid, if0.res_y, if0.res_id, if0.res_co);
        end
        @(negedge clk);
        checks++;
        if (if0.res_valid !== 1'b0 || if0.busy !== 1'b0) begin
            errors++;
            $display("FAIL pipe0_k2 got valid=%0b busy=%0b want 0 0", if0.res_valid, if0.busy);
        end
    endtask

`ifdef DP_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        if1.req0_valid = 1'b1; if1.req0_a = 16'd1; if1.req0_b = 16'd1; if1.req0_op = OP_ADD;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gc0_1 !== 16'd10 || gc1_1 !== 16'd0) begin
            errors++; $display("FAIL stats_early got cnt0=%0d cnt1=%0d want 10 0", gc0_1, gc1_1);
        end
        repeat (69990) @(posedge clk);
        @(negedge clk);
        if1.req0_valid = 1'b0;
        checks++;
        if (gc0_1 !== 16'hFFFF || gc1_1 !== 16'd0) begin
            errors++; $display("FAIL stats_sat got cnt0=%0h cnt1=%0h want ffff 0", gc0_1, gc1_1);
        end
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_streaming();
        test_reset_midflight();
        test_pipe0();
`ifdef DP_ARB_STATS_EN
        test_stats();
`endif
        repeat (6) @(negedge clk);
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending u1=%0d u0=%0d want 0 0", q1.size(), q0.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
